// File: rtl/irom_pkg.sv
// Shared constants, response record and address checks for the instruction ROM.
package irom_pkg;

    localparam int unsigned XLEN_WIDTH       = 32;
    localparam int unsigned IROM_DEPTH       = 1024;
    localparam int unsigned IROM_LATENCY_MAX = 4;

    typedef struct packed {
        logic                  err;
        logic [XLEN_WIDTH-1:0] data;
    } irom_rsp_t;

    // True when a byte address is not word aligned or lies past the last array word.
    function automatic logic word_addr_err(input logic [XLEN_WIDTH-1:0] addr,
                                           input int unsigned           depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/irom_sync_fifo.sv
// Synchronous FIFO with count and full/empty flags; depth need not be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/irom.sv
// Instruction ROM responder: fixed-latency read pipeline feeding an in-order response FIFO,
// with credit-based request flow control and a word-write load port.
module irom
    import irom_pkg::*;
#(
    parameter int unsigned DEPTH   = IROM_DEPTH,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XLEN_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [XLEN_WIDTH-1:0] ld_addr,
    input  logic [XLEN_WIDTH-1:0] ld_data
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SLOTS = LATENCY + 1;
    localparam int unsigned OW    = $clog2(SLOTS + 1);

    logic [XLEN_WIDTH-1:0] mem_q [DEPTH];
    logic [LATENCY-1:0]    vld_q;
    irom_rsp_t             stg_q [LATENCY];
    irom_rsp_t             stg0_d;
    irom_rsp_t             head;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  req_acc, rsp_hs, ld_ok;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic [OW-1:0]         fifo_count_unused;

    assign rsp_hs  = rsp_valid && rsp_ready;
    // A response handshake frees its credit in the same cycle, so a full pipe refills without a bubble.
    assign req_ready = rst && ((occ_q < OW'(SLOTS)) || rsp_hs);
    assign req_acc   = req_valid && req_ready;
    assign ld_ok     = rst && ld_en && !word_addr_err(ld_addr, DEPTH);

    always_comb begin
        stg0_d.err  = word_addr_err(req_addr, DEPTH);
        stg0_d.data = stg0_d.err ? '0 : mem_q[req_addr[AW+1:2]];
    end

    always_comb begin
        case ({req_acc, rsp_hs})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
            vld_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            vld_q[0] <= req_acc;
            stg_q[0] <= stg0_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    // Array is not reset; a same-cycle fetch sees the old word because stage 0 samples before this write lands.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_q[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    sync_fifo #(
        .WIDTH($bits(irom_rsp_t)),
        .DEPTH(SLOTS)
    ) u_rsp_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (vld_q[LATENCY-1]),
        .data_i (stg_q[LATENCY-1]),
        .pop_i  (rsp_hs),
        .data_o (head),
        .full_o (fifo_full_unused),
        .empty_o(fifo_empty),
        .count_o(fifo_count_unused)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_irom.sv
// Self-checking bench for irom: directed scenarios plus randomized traffic against a queue model.
module tb_irom;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned SLOTS = LAT + 1;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en;
    logic [31:0] req_addr, rsp_data, ld_addr, ld_data;

    irom #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } obs_t;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] prog [4];
    exp_t        exp_q [$];
    obs_t        pop_log [$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned dut_acc = 0;
    int unsigned dut_occ = 0;
    int unsigned dut_occ_max = 0;
    logic        model_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(15);
        if (r == 0) return $urandom;
        if (r == 1) return 32'($urandom_range(DEPTH - 1)) * 4 + 32'($urandom_range(3));
        return 32'($urandom_range(DEPTH - 1)) * 4;
    endfunction

    // One clock cycle: inputs are already driven; check outputs at negedge, then advance the model.
    task automatic tick();
        logic exp_v;
        exp_t e;
        @(negedge clk);
        exp_v     = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        model_rdy = rst && ((exp_q.size() < SLOTS) || (exp_v && rsp_ready));
        chk("rsp_valid", rsp_valid, exp_v);
        chk("req_ready", req_ready, model_rdy);
        if (exp_v) begin
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_err", rsp_err, exp_q[0].err);
        end
        if (rsp_valid && rsp_ready) pop_log.push_back({rsp_err, rsp_data});
        if (req_valid && req_ready) begin
            dut_acc++;
            dut_occ++;
        end
        if (rsp_valid && rsp_ready && dut_occ > 0) dut_occ--;
        if (dut_occ > dut_occ_max) dut_occ_max = dut_occ;
        if (!rst) begin
            exp_q.delete();
            dut_occ = 0;
        end else begin
            if (exp_v && rsp_ready) void'(exp_q.pop_front());
            if (req_valid && model_rdy) begin
                e.err  = bad_addr(req_addr);
                e.data = e.err ? 32'd0 : ref_mem[(req_addr / 4) % DEPTH];
                e.due  = cyc + SLOTS;
                exp_q.push_back(e);
            end
            if (ld_en && !bad_addr(ld_addr)) ref_mem[(ld_addr / 4) % DEPTH] = ld_data;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fetch(input logic [31:0] a);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = model_rdy;
        end
        if (!done) chk("fetch_timeout", 1, 0);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idx;
        int unsigned acc0;
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113;
        prog[3] = 32'h0030_0193;

        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
        req_addr = '0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            ld_en = 1'b1; ld_addr = 32'(i) * 4; ld_data = $urandom;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            ld_addr = 32'(i) * 4; ld_data = prog[i];
            tick();
        end
        ld_en = 1'b0;

        // Back-to-back program fetch.
        pop_log.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) fetch(32'(i) * 4);
        drain();
        chk("seq_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("seq_word", pop_log[i], {1'b0, prog[i]});

        // Misaligned and out-of-range fetches around a good one.
        pop_log.delete();
        fetch(32'h6);
        fetch(32'h4);
        fetch(32'h1000);
        drain();
        chk("err_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("err_misaligned", pop_log[0], {1'b1, 32'd0});
            chk("err_between", pop_log[1], {1'b0, prog[1]});
            chk("err_range", pop_log[2], {1'b1, 32'd0});
        end

        // Backpressure: credits run out, then one handshake frees exactly one slot.
        pop_log.delete();
        rsp_ready = 1'b0;
        acc0 = dut_acc;
        idx = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'(idx) * 4;
            tick();
            if (model_rdy) idx++;
        end
        chk("bp_accepts", dut_acc - acc0, SLOTS);
        rsp_ready = 1'b1;
        req_addr = 32'(idx) * 4;
        tick();
        chk("bp_release_accept", dut_acc - acc0, SLOTS + 1);
        chk("bp_release_pop", pop_log.size(), 1);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        drain();
        chk("bp_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("bp_order", pop_log[i], {1'b0, prog[i]});

        // Load and fetch of the same word in one cycle.
        pop_log.delete();
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
        fetch(32'h8);
        ld_en = 1'b0;
        fetch(32'h8);
        drain();
        chk("rbw_count", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            chk("rbw_old", pop_log[0].data, 32'h0020_0113);
            chk("rbw_new", pop_log[1].data, 32'hDEAD_BEEF);
        end

        // Reset with responses pending.
        pop_log.delete();
        rsp_ready = 1'b0;
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_mid_data", rsp_data, 0);
        chk("rst_mid_valid", rsp_valid, 0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("rst_no_stale", pop_log.size(), 0);
        fetch(32'h8);
        drain();
        chk("rst_intact", pop_log.size() == 1 ? pop_log[0] : 33'h0, {1'b0, 32'hDEAD_BEEF});

        // Random traffic.
        dut_occ_max = 0;
        req_valid = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!req_valid) begin
                req_valid = ($urandom_range(3) != 0);
                req_addr  = rand_addr();
            end
            rsp_ready = ($urandom_range(3) != 0);
            ld_en     = ($urandom_range(15) == 0);
            ld_addr   = rand_addr();
            ld_data   = $urandom;
            tick();
            if (req_valid && model_rdy) req_valid = 1'b0;
        end
        drain();
        chk("occ_max_bound", dut_occ_max <= SLOTS, 1);
        chk("occ_reached_full", dut_occ_max, SLOTS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
